// File: rtl/video_timing_if.sv
// Video timing generator bus: pixel-rate controls from the system side,
// coordinates, blanking, sync and strobes back to the core and display.
interface video_timing_if #(
  parameter int unsigned CNT_W = 9,
  parameter int unsigned RGB_W = 12
);
  logic             CE_PIX;
  logic             FLIP;
  logic [3:0]       H_SHIFT;
  logic [2:0]       V_SHIFT;
  logic [RGB_W-1:0] iRGB;
  logic [CNT_W-1:0] HPOS;
  logic [CNT_W-1:0] VPOS;
  logic [RGB_W-1:0] oRGB;
  logic             HBLK;
  logic             VBLK;
  logic             HSYN;
  logic             VSYN;
  logic             DE;
  logic             LINE_START;
  logic             FRAME_START;
  logic [7:0]       FRAME_CNT;

  modport master (
    output CE_PIX, FLIP, H_SHIFT, V_SHIFT, iRGB,
    input  HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, DE,
    input  LINE_START, FRAME_START, FRAME_CNT
  );

  modport slave (
    input  CE_PIX, FLIP, H_SHIFT, V_SHIFT, iRGB,
    output HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, DE,
    output LINE_START, FRAME_START, FRAME_CNT
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel coordinates for the game core,
// blanking/sync/DE realigned to the core's pixel data after PIX_LAT CE cycles.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 288,
  parameter int unsigned H_FP     = 20,
  parameter int unsigned H_SYNC   = 32,
  parameter int unsigned H_BP     = 44,
  parameter int unsigned V_ACTIVE = 224,
  parameter int unsigned V_FP     = 16,
  parameter int unsigned V_SYNC   = 8,
  parameter int unsigned V_BP     = 16,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 9,
  parameter int unsigned RGB_W    = 12,
  parameter int unsigned PIX_LAT  = 1
) (
  input logic           MCLK,
  input logic           RESET_N,
  video_timing_if.slave vt
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned SW      = CNT_W + 2;

  typedef struct packed {
    logic hblk;
    logic vblk;
    logic hsync;
    logic vsync;
  } flag_t;

  localparam flag_t FLAG_RST = '{hblk: 1'b1, vblk: 1'b1, hsync: 1'b0, vsync: 1'b0};

  logic [CNT_W-1:0]    h_q, v_q;
  logic                flip_q;
  logic signed [3:0]   hs_q;
  logic signed [2:0]   vs_q;
  logic                wrapped_q;
  flag_t               dly_q [PIX_LAT+1];

  logic                h_last, v_last, at_origin, in_active;
  logic [CNT_W-1:0]    hpos_c, vpos_c;
  logic signed [SW-1:0] h_s, v_s, hs_beg, hs_end, vs_beg, vs_end;
  flag_t               flag_c;
  flag_t               flag_out;

  // Counter position decode, coordinate mapping and stage-0 flag generation
  always_comb begin
    h_last    = (h_q == CNT_W'(H_TOTAL - 1));
    v_last    = (v_q == CNT_W'(V_TOTAL - 1));
    at_origin = (h_q == '0) && (v_q == '0);
    in_active = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));

    hpos_c = h_q;
    vpos_c = v_q;
    if (flip_q && in_active) begin
      hpos_c = CNT_W'(H_ACTIVE - 1) - h_q;
      vpos_c = CNT_W'(V_ACTIVE - 1) - v_q;
    end

    h_s    = signed'({2'b00, h_q});
    v_s    = signed'({2'b00, v_q});
    hs_beg = SW'(H_ACTIVE + H_FP) + SW'(hs_q);
    hs_end = hs_beg + SW'(H_SYNC);
    vs_beg = SW'(V_ACTIVE + V_FP) + SW'(vs_q);
    vs_end = vs_beg + SW'(V_SYNC);

    flag_c.hblk  = (h_q >= CNT_W'(H_ACTIVE));
    flag_c.vblk  = (v_q >= CNT_W'(V_ACTIVE));
    flag_c.hsync = (h_s >= hs_beg) && (h_s < hs_end);
    flag_c.vsync = (v_s >= vs_beg) && (v_s < vs_end);

    flag_out = dly_q[PIX_LAT];
  end

  // Raster position counters
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      h_q <= '0;
      v_q <= '0;
    end else if (vt.CE_PIX) begin
      if (h_last) begin
        h_q <= '0;
        v_q <= v_last ? '0 : v_q + 1'b1;
      end else begin
        h_q <= h_q + 1'b1;
      end
    end
  end

  // Per-frame controls are captured as the counter wraps into the new frame
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      flip_q    <= 1'b0;
      hs_q      <= '0;
      vs_q      <= '0;
      wrapped_q <= 1'b0;
    end else if (vt.CE_PIX && h_last && v_last) begin
      flip_q    <= vt.FLIP;
      hs_q      <= vt.H_SHIFT;
      vs_q      <= vt.V_SHIFT;
      wrapped_q <= 1'b1;
    end
  end

  // Coordinates, line/frame strobes and frame counter, aligned with HPOS
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vt.HPOS        <= '0;
      vt.VPOS        <= '0;
      vt.LINE_START  <= 1'b0;
      vt.FRAME_START <= 1'b0;
      vt.FRAME_CNT   <= '0;
    end else begin
      vt.LINE_START  <= vt.CE_PIX && (h_q == '0);
      vt.FRAME_START <= vt.CE_PIX && at_origin && wrapped_q;
      if (vt.CE_PIX) begin
        vt.HPOS <= hpos_c;
        vt.VPOS <= vpos_c;
        if (at_origin && wrapped_q) begin
          vt.FRAME_CNT <= vt.FRAME_CNT + 8'd1;
        end
      end
    end
  end

  // Stage 0 plus PIX_LAT-deep delay line matching the core's pixel latency
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i <= PIX_LAT; i++) begin
        dly_q[i] <= FLAG_RST;
      end
    end else if (vt.CE_PIX) begin
      dly_q[0] <= flag_c;
      for (int i = 0; i < PIX_LAT; i++) begin
        dly_q[i+1] <= dly_q[i];
      end
    end
  end

  // Output register: polarity, DE and blanked pixel data
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vt.HBLK <= 1'b1;
      vt.VBLK <= 1'b1;
      vt.HSYN <= ~HS_POL;
      vt.VSYN <= ~VS_POL;
      vt.DE   <= 1'b0;
      vt.oRGB <= '0;
    end else if (vt.CE_PIX) begin
      vt.HBLK <= flag_out.hblk;
      vt.VBLK <= flag_out.vblk;
      vt.HSYN <= flag_out.hsync ? HS_POL : ~HS_POL;
      vt.VSYN <= flag_out.vsync ? VS_POL : ~VS_POL;
      vt.DE   <= ~(flag_out.hblk | flag_out.vblk);
      vt.oRGB <= (flag_out.hblk | flag_out.vblk) ? '0 : vt.iRGB;
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: directed frame table plus randomized run against
// an arithmetic model indexed by the number of CE cycles since reset.
module tb_video_timing_gen;
  localparam int HA = 6, HFP = 9, HSY = 2, HBP = 9;
  localparam int VA = 4, VFP = 1, VSY = 2, VBP = 1;
  localparam bit HS_POL = 1'b0, VS_POL = 1'b1;
  localparam int CNT_W = 6, RGB_W = 12, PIX_LAT = 3;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int FT  = HT * VT;
  localparam int LAT = PIX_LAT + 1;

  logic MCLK = 1'b0;
  logic RESET_N;

  video_timing_if #(.CNT_W(CNT_W), .RGB_W(RGB_W)) vif ();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL),
    .CNT_W(CNT_W), .RGB_W(RGB_W), .PIX_LAT(PIX_LAT)
  ) dut (
    .MCLK(MCLK),
    .RESET_N(RESET_N),
    .vt(vif)
  );

  always #5 MCLK = ~MCLK;

  typedef struct packed {
    logic [CNT_W-1:0] hpos;
    logic [CNT_W-1:0] vpos;
    logic [RGB_W-1:0] rgb;
    logic hblk, vblk, hsyn, vsyn, de, ls, fs;
    logic [7:0] fcnt;
  } obs_t;

  typedef struct {
    bit flip; int hsh; int vsh;
    int hs_beg; int hs_end; int hpos0; int vpos0; int de_cnt;
  } row_t;

  int   k;
  int   lat_flip [1024];
  int   lat_hs   [1024];
  int   lat_vs   [1024];
  int   n_vec, n_miss;
  int   prev_fc;
  bit   saw_wrap;
  row_t rows [4];

  // Pixel pattern the emulated core returns for a presented coordinate
  function automatic logic [RGB_W-1:0] pattern(input int hp, input int vp);
    return RGB_W'((vp << CNT_W) | hp) ^ RGB_W'(12'h5A3);
  endfunction

  // Presented coordinate of the n-th raster position since reset
  function automatic void coords(input int n, output int hp, output int vp);
    int h, v, f;
    h = n % HT;
    v = (n / HT) % VT;
    f = n / FT;
    if (lat_flip[f] != 0 && h < HA && v < VA) begin
      hp = HA - 1 - h;
      vp = VA - 1 - v;
    end else begin
      hp = h;
      vp = v;
    end
  endfunction

  // Expected outputs after k CE cycles since reset
  function automatic obs_t model(input bit ce_now);
    obs_t e;
    int hp, vp, m, h, v, f, b;
    bit hb, vb, ha, va;
    e = '0;
    if (k == 0) begin
      e.hblk = 1'b1; e.vblk = 1'b1;
      e.hsyn = ~HS_POL; e.vsyn = ~VS_POL;
      return e;
    end
    coords(k - 1, hp, vp);
    e.hpos = CNT_W'(hp);
    e.vpos = CNT_W'(vp);
    m = k - LAT - 1;
    hb = 1'b1; vb = 1'b1; ha = 1'b0; va = 1'b0;
    if (m >= 0) begin
      h = m % HT;
      v = (m / HT) % VT;
      f = m / FT;
      hb = (h >= HA);
      vb = (v >= VA);
      b  = HA + HFP + lat_hs[f];
      ha = (h >= b) && (h < b + HSY);
      b  = VA + VFP + lat_vs[f];
      va = (v >= b) && (v < b + VSY);
      coords(m, hp, vp);
      e.rgb = (hb || vb) ? '0 : pattern(hp, vp);
    end
    e.hblk = hb;
    e.vblk = vb;
    e.hsyn = ha ? HS_POL : ~HS_POL;
    e.vsyn = va ? VS_POL : ~VS_POL;
    e.de   = !(hb || vb);
    e.ls   = ce_now && ((k - 1) % HT == 0);
    e.fs   = ce_now && ((k - 1) % FT == 0) && (k - 1 >= FT);
    e.fcnt = 8'(((k - 1) / FT) % 256);
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a = {vif.HPOS, vif.VPOS, vif.oRGB, vif.HBLK, vif.VBLK, vif.HSYN, vif.VSYN,
         vif.DE, vif.LINE_START, vif.FRAME_START, vif.FRAME_CNT};
    return a;
  endfunction

  task automatic check_obs(input string tag, input bit ce_now);
    obs_t e, a;
    e = model(ce_now);
    a = sample();
    n_vec++;
    if (a !== e) begin
      n_miss++;
      $display("FAIL %s k=%0d got hpos=%0d vpos=%0d rgb=%h hb=%b vb=%b hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d want hpos=%0d vpos=%0d rgb=%h hb=%b vb=%b hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
               tag, k, a.hpos, a.vpos, a.rgb, a.hblk, a.vblk, a.hsyn, a.vsyn, a.de, a.ls, a.fs, a.fcnt,
               e.hpos, e.vpos, e.rgb, e.hblk, e.vblk, e.hsyn, e.vsyn, e.de, e.ls, e.fs, e.fcnt);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic rand_inputs();
    vif.FLIP    = 1'($urandom_range(0, 1));
    vif.H_SHIFT = 4'($urandom);
    vif.V_SHIFT = 3'($urandom);
  endtask

  // One MCLK: drive at negedge, advance model at posedge, compare after it
  task automatic step(input bit ce);
    int hp, vp, m;
    @(negedge MCLK);
    vif.CE_PIX = ce;
    vif.iRGB   = RGB_W'($urandom);
    m = k - LAT;
    if (ce && m >= 0) begin
      coords(m, hp, vp);
      vif.iRGB = pattern(hp, vp);
    end
    @(posedge MCLK);
    if (RESET_N && ce) begin
      k++;
      if (k % FT == 0) begin
        lat_flip[k / FT] = int'(vif.FLIP);
        lat_hs[k / FT]   = int'($signed(vif.H_SHIFT));
        lat_vs[k / FT]   = int'($signed(vif.V_SHIFT));
      end
    end
    #1;
    check_obs("cycle", ce);
    if (vif.FRAME_START === 1'b1) begin
      if (prev_fc == 255 && vif.FRAME_CNT == 8'd0) saw_wrap = 1'b1;
      prev_fc = int'(vif.FRAME_CNT);
    end
  endtask

  task automatic wait_fs(input int limit, output int n, output bit found);
    n = 0;
    found = 1'b0;
    while (!found && n < limit) begin
      step(1'b1);
      n++;
      if (vif.FRAME_START === 1'b1) found = 1'b1;
    end
  endtask

  initial begin
    int  n, raw, hs_b, hs_e, de_cnt, guard;
    bit  found;

    rows[0] = '{flip: 1'b0, hsh:  0, vsh:  0, hs_beg: 15, hs_end: 17, hpos0: 0, vpos0: 0, de_cnt: 24};
    rows[1] = '{flip: 1'b1, hsh: -8, vsh: -4, hs_beg:  7, hs_end:  9, hpos0: 5, vpos0: 3, de_cnt: 24};
    rows[2] = '{flip: 1'b0, hsh:  7, vsh:  3, hs_beg: 22, hs_end: 24, hpos0: 0, vpos0: 0, de_cnt: 24};
    rows[3] = '{flip: 1'b1, hsh:  3, vsh:  0, hs_beg: 18, hs_end: 20, hpos0: 5, vpos0: 3, de_cnt: 24};

    k = 0; n_vec = 0; n_miss = 0; prev_fc = -1; saw_wrap = 1'b0;
    lat_flip[0] = 0; lat_hs[0] = 0; lat_vs[0] = 0;
    RESET_N = 1'b0;
    vif.CE_PIX = 1'b0; vif.FLIP = 1'b0; vif.H_SHIFT = '0; vif.V_SHIFT = '0; vif.iRGB = '0;

    // Reset state, including controls that would otherwise take effect
    vif.FLIP = 1'b1; vif.H_SHIFT = 4'(-8);
    step(1'b1);
    step(1'b0);
    @(negedge MCLK);
    RESET_N = 1'b1;
    vif.FLIP = 1'b0; vif.H_SHIFT = '0;

    // Directed frames: per-frame controls, HSYNC window, flip origin, DE count
    for (int r = 0; r < 4; r++) begin
      vif.FLIP    = rows[r].flip;
      vif.H_SHIFT = 4'(rows[r].hsh);
      vif.V_SHIFT = 3'(rows[r].vsh);
      wait_fs(2 * FT + LAT + 4, n, found);
      check_int("first_frame_start_seen", int'(found), 1);
      wait_fs(FT + 4, n, found);
      check_int("frame_start_period", n, FT);
      check_int("frame_origin_hpos", int'(vif.HPOS), rows[r].hpos0);
      check_int("frame_origin_vpos", int'(vif.VPOS), rows[r].vpos0);
      hs_b = -1; hs_e = -1; de_cnt = 0;
      for (int t = 1; t <= FT; t++) begin
        step(1'b1);
        raw = t - LAT;
        if (raw >= 0 && raw < HT) begin
          if (hs_b < 0 && vif.HSYN == HS_POL) hs_b = raw;
          if (hs_b >= 0 && hs_e < 0 && vif.HSYN != HS_POL) hs_e = raw;
        end
        if (vif.DE === 1'b1) de_cnt++;
      end
      check_int("hsync_first_pixel", hs_b, rows[r].hs_beg);
      check_int("hsync_end_pixel", hs_e, rows[r].hs_end);
      check_int("de_pixels_per_frame", de_cnt, rows[r].de_cnt);
    end

    // Random CE gating with controls changing at arbitrary points in the frame
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step($urandom_range(0, 3) != 0);
    end

    // Asynchronous reset mid-frame, away from any clock edge
    guard = 0;
    while (((k - 1) % FT) != 2 * HT + 10 && guard < 4 * FT) begin
      rand_inputs();
      step($urandom_range(0, 3) != 0);
      guard++;
    end
    check_int("reached_reset_point", int'(((k - 1) % FT) == 2 * HT + 10), 1);
    #1;
    RESET_N = 1'b0;
    #1;
    k = 0;
    check_obs("async_reset", 1'b0);
    check_int("async_reset_frame_cnt", int'(vif.FRAME_CNT), 0);
    #1;
    RESET_N = 1'b1;

    // Long run through the 8-bit frame counter wrap
    while (k < 257 * FT + 10) begin
      rand_inputs();
      step(1'b1);
    end
    check_int("frame_cnt_wrap_255_to_0", int'(saw_wrap), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
